ps2_rx_fifo: RTL and testbench

// - Synchronous PS/2 keyboard receiver. Successor to the negedge-PS2C scan-code catcher.
// - Oversamples PS2C/PS2D on the system clock, deglitches them and checks full frames (start/parity/stop).
// - Decodes E0/F0 prefixes into make/break events and queues them in a FIFO with a valid/ready read port.
// - Sits between the keyboard pins and the game/control logic that consumes key events.

---
 rtl/ps2_rx_fifo.sv | 258 +++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// Synchronous PS/2 keyboard receiver: oversampled, deglitched frame checker, E0/F0 decoder, FWFT event FIFO.
// Optional odd-parity enforcement via `define PS2_PARITY_CHECK_EN.
package ps2_rx_fifo_pkg;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;
endpackage

module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rStarted,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_code,
  output logic                          out_brk,
  output logic                          out_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          err_frame,
  output logic                          err_parity,
  output logic                          err_timeout,
  output logic                          err_overflow
);
  localparam int unsigned FW = $clog2(FILTER_LEN);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Input path: index 0 = PS2C, index 1 = PS2D
  logic [1:0]    s1_q, s2_q, flt_q, flt_d;
  logic [FW-1:0] flt_cnt_q [2];
  logic [FW-1:0] flt_cnt_d [2];
  logic          clk_prev_q;
  logic          fall_c, din_c;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          busy_q, busy_d;
  logic          err_frame_q, err_frame_d;
  logic          err_timeout_q, err_timeout_d;
  logic          byte_done_c;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q, par_d;
  logic          err_parity_q, err_parity_d;
`endif

  logic          ext_q, ext_d, brk_q, brk_d;
  logic          push_q, push_d;
  ps2_evt_t      push_evt_q, push_evt_d;

  ps2_evt_t      mem_q [FIFO_DEPTH];
  ps2_evt_t      mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  ps2_evt_t      head_q, head_d;
  logic          ovf_q, ovf_d;
  logic          pop_c, full_c, wr_en_c;

  // Run-length filter: level flips only after FILTER_LEN consecutive differing samples
  always_comb begin
    flt_d = flt_q;
    for (int i = 0; i < 2; i++) begin
      flt_cnt_d[i] = '0;
      if (s2_q[i] != flt_q[i]) begin
        if (flt_cnt_q[i] == FW'(FILTER_LEN - 1)) flt_d[i] = s2_q[i];
        else flt_cnt_d[i] = flt_cnt_q[i] + FW'(1);
      end
    end
  end

  assign fall_c = clk_prev_q & ~flt_q[0];
  assign din_c  = flt_q[1];

  // Frame FSM and inactivity timeout
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    to_cnt_d      = to_cnt_q;
    err_frame_d   = 1'b0;
    err_timeout_d = 1'b0;
    byte_done_c   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d         = par_q;
    err_parity_d  = 1'b0;
`endif
    if (fall_c) begin
      to_cnt_d = '0;
      case (state_q)
        S_IDLE: if (!din_c) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
        S_DATA: begin
          shift_d   = {din_c, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = din_c;
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!din_c) err_frame_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
          else if (!(^{shift_q, par_q})) err_parity_d = 1'b1;
`endif
          else byte_done_c = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d       = S_IDLE;
        to_cnt_d      = '0;
        err_timeout_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // Prefix decoder: E0/F0 arm flags, any other byte becomes an event
  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    push_d     = 1'b0;
    push_evt_d = push_evt_q;
    if (err_timeout_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_done_c) begin
      if (shift_q == 8'hE0) ext_d = 1'b1;
      else if (shift_q == 8'hF0) brk_d = 1'b1;
      else begin
        push_d     = 1'b1;
        push_evt_d = '{ext: ext_q, brk: brk_q, code: shift_q};
        ext_d      = 1'b0;
        brk_d      = 1'b0;
      end
    end
  end

  // FWFT FIFO; head is re-registered so the read port is flop-driven
  always_comb begin
    pop_c    = valid_q & out_ready;
    full_c   = (count_q == CW'(FIFO_DEPTH));
    wr_en_c  = push_q & (~full_c | pop_c);
    ovf_d    = push_q & full_c & ~pop_c;
    mem_d    = mem_q;
    if (wr_en_c) mem_d[wr_ptr_q] = push_evt_q;
    wr_ptr_d = wr_ptr_q + PW'(wr_en_c);
    rd_ptr_d = rd_ptr_q + PW'(pop_c);
    count_d  = count_q + CW'(wr_en_c) - CW'(pop_c);
    valid_d  = (count_d != '0);
    if (count_d == '0) head_d = '0;
    else if (wr_en_c && (wr_ptr_q == rd_ptr_d)) head_d = push_evt_q;
    else head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rStarted) begin
    if (!rStarted) begin
      s1_q          <= 2'b11;
      s2_q          <= 2'b11;
      flt_q         <= 2'b11;
      flt_cnt_q[0]  <= '0;
      flt_cnt_q[1]  <= '0;
      clk_prev_q    <= 1'b1;
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      to_cnt_q      <= '0;
      busy_q        <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q         <= 1'b0;
      err_parity_q  <= 1'b0;
`endif
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      push_q        <= 1'b0;
      push_evt_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      head_q        <= '0;
      ovf_q         <= 1'b0;
    end else begin
      s1_q          <= {ps2_data, ps2_clk};
      s2_q          <= s1_q;
      flt_q         <= flt_d;
      flt_cnt_q     <= flt_cnt_d;
      clk_prev_q    <= flt_q[0];
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      to_cnt_q      <= to_cnt_d;
      busy_q        <= busy_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q         <= par_d;
      err_parity_q  <= err_parity_d;
`endif
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      push_q        <= push_d;
      push_evt_q    <= push_evt_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      head_q        <= head_d;
      ovf_q         <= ovf_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_code     = head_q.code;
  assign out_brk      = head_q.brk;
  assign out_ext      = head_q.ext;
  assign fifo_count   = count_q;
  assign busy         = busy_q;
  assign err_frame    = err_frame_q;
  assign err_timeout  = err_timeout_q;
  assign err_overflow = ovf_q;
`ifdef PS2_PARITY_CHECK_EN
  assign err_parity   = err_parity_q;
`else
  assign err_parity   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames, prefixes, overflow, errors, timeout, glitch and reset.
module tb_ps2_rx_fifo;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 2000;

  logic       clk = 1'b0;
  logic       rStarted, ps2_clk, ps2_data, out_ready;
  logic       out_valid, out_brk, out_ext, busy;
  logic [7:0] out_code;
  logic [3:0] fifo_count;
  logic       err_frame, err_parity, err_timeout, err_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ef = 0, n_ep = 0, n_et = 0, n_eo = 0;

  ps2_rx_fifo #(.FILTER_LEN(4), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rStarted(rStarted), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_brk(out_brk), .out_ext(out_ext), .fifo_count(fifo_count), .busy(busy),
    .err_frame(err_frame), .err_parity(err_parity), .err_timeout(err_timeout),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (err_frame)    n_ef++;
    if (err_parity)   n_ep++;
    if (err_timeout)  n_et++;
    if (err_overflow) n_eo++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  // nbits < 11 sends a truncated frame
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    wait_cyc(10);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [7:0] code, input logic brk, input logic ext);
    check({tag, "_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_code"}, 32'(out_code), 32'(code));
    check({tag, "_brk"}, 32'(out_brk), 32'(brk));
    check({tag, "_ext"}, 32'(out_ext), 32'(ext));
  endtask

  initial begin
    logic [7:0] codes [9];
    int         base;
    bit         busy_seen;
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    rStarted = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0;
    wait_cyc(5);
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_code", 32'(out_code), 32'(0));
    check("rst_count", 32'(fifo_count), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_errs", 32'({err_frame, err_parity, err_timeout, err_overflow}), 32'(0));
    rStarted = 1'b1;
    wait_cyc(5);

    // Plain make code
    send_frame(8'h1C, 0, 0, 11);
    expect_head("make1c", 8'h1C, 0, 0);
    check("make1c_count", 32'(fifo_count), 32'(1));
    pop_one();
    check("make1c_popped", 32'(fifo_count), 32'(0));
    check("make1c_empty", 32'(out_valid), 32'(0));

    // Break and extended break
    send_frame(8'hF0, 0, 0, 11);
    check("f0_no_event", 32'(out_valid), 32'(0));
    send_frame(8'h1C, 0, 0, 11);
    expect_head("brk1c", 8'h1C, 1, 0);
    check("brk1c_count", 32'(fifo_count), 32'(1));
    pop_one();
    send_frame(8'hE0, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h75, 0, 0, 11);
    expect_head("extbrk75", 8'h75, 1, 1);
    pop_one();
    check("extbrk_empty", 32'(fifo_count), 32'(0));

    // Overflow: DEPTH+1 makes with no reads
    base = n_eo;
    for (int i = 0; i < 9; i++) send_frame(codes[i], 0, 0, 11);
    check("ovf_count", 32'(fifo_count), 32'(DEPTH));
    check("ovf_pulses", 32'(n_eo - base), 32'(1));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_code", i), 32'(out_code), 32'(codes[i]));
      pop_one();
    end
    check("drain_empty", 32'(out_valid), 32'(0));
    check("drain_count", 32'(fifo_count), 32'(0));

    // Bad stop bit
    base = n_ef;
    send_frame(8'h1C, 0, 1, 11);
    check("frame_pulse", 32'(n_ef - base), 32'(1));
    check("frame_no_event", 32'(out_valid), 32'(0));

    // Flipped parity
    base = n_ep;
    send_frame(8'h1C, 1, 0, 11);
`ifdef PS2_PARITY_CHECK_EN
    check("par_pulse", 32'(n_ep - base), 32'(1));
    check("par_no_event", 32'(out_valid), 32'(0));
`else
    check("par_pulse", 32'(n_ep - base), 32'(0));
    expect_head("par_ignored", 8'h1C, 0, 0);
    pop_one();
`endif

    // Timeout after 4 data bits (start + 4)
    base = n_et;
    send_frame(8'hA5, 0, 0, 5);
    check("to_busy", 32'(busy), 32'(1));
    wait_cyc(TO + 100);
    check("to_pulse", 32'(n_et - base), 32'(1));
    check("to_idle", 32'(busy), 32'(0));
    check("to_no_event", 32'(out_valid), 32'(0));
    send_frame(8'h2A, 0, 0, 11);
    expect_head("after_to", 8'h2A, 0, 0);
    pop_one();

    // Short PS2C glitch in IDLE
    busy_seen = 0;
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    check("glitch_busy", 32'(busy_seen), 32'(0));

    // Reset mid-frame with a queued event
    send_frame(8'h1C, 0, 0, 11);
    check("pre_rst_count", 32'(fifo_count), 32'(1));
    send_frame(8'h33, 0, 0, 4);
    check("pre_rst_busy", 32'(busy), 32'(1));
    rStarted = 1'b0;
    wait_cyc(3);
    check("mid_rst_outs", 32'({out_valid, out_code, out_brk, out_ext, busy}), 32'(0));
    check("mid_rst_count", 32'(fifo_count), 32'(0));
    rStarted = 1'b1;
    wait_cyc(200);
    check("post_rst_valid", 32'(out_valid), 32'(0));
    check("post_rst_count", 32'(fifo_count), 32'(0));
    check("post_rst_busy", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
